text_buffer_ctrl: RTL and testbench
===================================

Name: text_buffer_ctrl

Overview:
- Owns the 26-cell English text area shown by the screen mux: two rows of 13 character codes, each cell feeding one CharDraw instance.
- Accepts decoded characters from the Xbee/Morse decode path over a valid/ready handshake.
- Maintains a write cursor and sequences the multi-cycle clear and scroll operations.
- The buffer has a single write port (at most one cell written per cycle) so it can later map to distributed RAM.

Parameters:
- COLS, 13, cells per row.
- ROWS, 2, number of rows. The logic is written for 2.
- BLANK, 8'h20, code written to empty cells.
- BLINK_DIV, 24'd6000000, cclk cycles per cursor blink half-period. Used only with CURSOR_BLINK_EN.

Ports:
- cclk  in  1  system clock
- rstb  in  1  synchronous reset, active-high
- in_valid  in  1  in_char is presented
- in_char  in  8  character code
- in_ready  out  1  controller can accept a character this cycle
- cells  out  ROWS*COLS*8 (208)  flat cell array; cell i is at bits [8i+7:8i]; cells 0-12 are row 1, cells 13-25 are row 2
- cursor_idx  out  5  next write cell, 0..25
- busy  out  1  high while in SCROLL or CLEAR
- cursor_vis  out  1  cursor highlight enable

Behaviour:
- Reset (rstb high at a cclk edge):
  - all cells = BLANK; cursor_idx = 0; state = IDLE; busy = 0; cursor_vis = 1.
  - in_ready = 0 while rstb is high.
  - A reset during SCROLL or CLEAR aborts the operation immediately.
- Handshake:
  - in_ready = (state==IDLE) && !rstb, combinational.
  - A character is accepted when in_valid && in_ready at a rising edge.
  - in_char may change freely while in_ready = 0. Nothing is buffered.
- FSM states: IDLE, SCROLL, CLEAR. Each accepted code is handled in one cycle from IDLE; results are visible the next cycle.
- Printable code (0x20-0x7E):
  - cells[cursor] <= code.
  - If cursor < 25: cursor <= cursor+1, stay in IDLE.
  - If cursor == 25: enter SCROLL.
- 0x08 (backspace):
  - If cursor > 0: cursor <= cursor-1 and cells[cursor-1] <= BLANK.
  - If cursor == 0: no effect.
- 0x0A (newline):
  - If cursor < 13: cursor <= 13.
  - Otherwise: enter SCROLL. Any partial row 2 content moves to row 1.
- 0x0C (clear): enter CLEAR.
- Any other code: accepted and ignored.
- SCROLL (26 cycles, busy = 1, one cell written per cycle):
  - Index k runs 0..25.
  - For k < 13: cells[k] <= cells[k+13].
  - For k >= 13: cells[k] <= BLANK.
  - After k == 25: cursor <= 13, return to IDLE.
- CLEAR (26 cycles, busy = 1): cells[k] <= BLANK for k = 0..25, then cursor <= 0 and return to IDLE.
- Busy timing: busy asserts the cycle after the triggering accept. in_ready falls in the same cycle busy rises, and rises the cycle after the final write.
- The internal 5-bit sequencing index k is separate from the cursor. k must never address a cell above 25.

Optional Feature:
- Macro: CURSOR_BLINK_EN.
- When defined:
  - A 24-bit counter counts cclk cycles. At BLINK_DIV-1 it wraps to 0 and toggles cursor_vis.
  - Any accepted character, and reset, sets the counter to 0 and cursor_vis to 1.
  - cursor_vis holds at 1 while busy.
- When not defined: cursor_vis is tied to 1 and no counter is synthesized.

Decomposition:
- Shared package screen_pkg holds:
  - COLS, ROWS, NCELLS = 26;
  - BLANK, CH_BS = 8'h08, CH_LF = 8'h0A, CH_FF = 8'h0C;
  - the state enum {IDLE, SCROLL, CLEAR}.
- Natural sub-module: cursor_blinker (counter plus cursor_vis), instantiated only under CURSOR_BLINK_EN.
- The cell array and FSM stay in text_buffer_ctrl.

Test Plan:
- Reset, then present "HI" (0x48, 0x49) back-to-back with in_valid held:
  - cells[0] = 0x48, cells[1] = 0x49, cursor_idx = 2;
  - in_ready stays 1 throughout;
  - all other cells = 0x20.
- Write 26 printable codes 'A'..'Z':
  - busy rises after 'Z' is accepted and lasts exactly 26 cycles;
  - afterwards cells[0..12] = 'N'..'Z', cells[13..25] = 0x20, cursor_idx = 13;
  - in_valid held during busy is not accepted.
- Write 'A', 'B', then 0x08 twice, then 0x08 again: cursor_idx goes 2 -> 1 -> 0 -> 0; cells[0..1] = 0x20.
- At cursor_idx = 5, send 0x0A: cursor_idx = 13 with busy = 0. Write 'Q', then 0x0A: SCROLL runs; cells[0] = 'Q', cursor_idx = 13.
- With the buffer partly full, send 0x0C:
  - busy is high for 26 cycles; all cells = 0x20; cursor_idx = 0.
  - In a second run, assert rstb on CLEAR cycle 10: the next cycle has state IDLE, busy = 0, all cells 0x20.
- With CURSOR_BLINK_EN and BLINK_DIV = 4:
  - cursor_vis toggles every 4 cycles while idle;
  - an accepted character forces cursor_vis = 1 and restarts the count;
  - built without the macro, cursor_vis is constant 1.

Source files
------------

// File: rtl/screen_pkg.sv
`default_nettype none
// ============================================================================
// Package     : screen_pkg
// Description : Shared geometry, character codes and state encoding for the
//               screen text area.
// Revision    : 1.0 - initial release
// ============================================================================
package screen_pkg;

    localparam int COLS   = 13;
    localparam int ROWS   = 2;
    localparam int NCELLS = ROWS * COLS;

    localparam logic [7:0] BLANK = 8'h20;
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;

    // 5-bit forms of the geometry so index comparisons stay width-matched
    localparam logic [4:0] c_row2_start = 5'(COLS);
    localparam logic [4:0] c_last_cell  = 5'(NCELLS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        CLEAR  = 2'd2
    } state_t;

    function automatic logic is_printable(input logic [7:0] code);
        return (code >= 8'h20) && (code <= 8'h7E);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cursor_blinker.sv
`default_nettype none
// ============================================================================
// Module      : cursor_blinker
// Description : Cursor blink generator. Toggles o_vis every BLINK_DIV cycles;
//               a restart or hold forces o_vis high and restarts the count.
// Revision    : 1.0 - initial release
// ============================================================================
module cursor_blinker #(
    parameter logic [23:0] BLINK_DIV = 24'd6000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    input  logic i_hold,
    output logic o_vis
);

    logic [23:0] r_cnt;
    logic        r_vis;

    // Half-period counter; restart/hold pin the cursor visible
    always_ff @(posedge clk) begin
        if (rst || i_restart || i_hold) begin
            r_cnt <= 24'd0;
            r_vis <= 1'b1;
        end else if (r_cnt == BLINK_DIV - 24'd1) begin
            r_cnt <= 24'd0;
            r_vis <= ~r_vis;
        end else begin
            r_cnt <= r_cnt + 24'd1;
        end
    end

    assign o_vis = r_vis;

endmodule
`default_nettype wire

// File: rtl/text_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : text_buffer_ctrl
// Description : 2x13 character text area with write cursor, backspace,
//               newline, and multi-cycle scroll/clear sequencing. One cell
//               write per cycle.
// Options     : CURSOR_BLINK_EN - adds cursor_blinker (BLINK_DIV parameter)
// Revision    : 1.0 - initial release
// ============================================================================
module text_buffer_ctrl
    import screen_pkg::*;
`ifdef CURSOR_BLINK_EN
#(
    parameter logic [23:0] BLINK_DIV = 24'd6000000
)
`endif
(
    input  logic                    cclk,
    input  logic                    rstb,
    input  logic                    in_valid,
    input  logic [7:0]              in_char,
    output logic                    in_ready,
    output logic [NCELLS*8-1:0]     cells,
    output logic [4:0]              cursor_idx,
    output logic                    busy,
    output logic                    cursor_vis
);

    state_t      r_state, w_state_next;
    logic [7:0]  r_cells [NCELLS];
    logic [4:0]  r_cursor, w_cursor_next;
    logic [4:0]  r_k, w_k_next;
    logic        w_we;
    logic [4:0]  w_waddr;
    logic [7:0]  w_wdata;
    logic [4:0]  w_src_idx;
    logic        w_accept;

    assign in_ready  = (r_state == IDLE) && !rstb;
    assign w_accept  = in_valid && in_ready;
    assign busy      = (r_state != IDLE);
    assign cursor_idx = r_cursor;

    // Scroll source is the same column one row down; only used while k < 13
    assign w_src_idx = (r_k < c_row2_start) ? (r_k + c_row2_start) : r_k;

    // State, cursor and sequencing index registers
    always_ff @(posedge cclk) begin
        if (rstb) begin
            r_state  <= IDLE;
            r_cursor <= 5'd0;
            r_k      <= 5'd0;
        end else begin
            r_state  <= w_state_next;
            r_cursor <= w_cursor_next;
            r_k      <= w_k_next;
        end
    end

    // Next-state logic and the single cell write port
    always_comb begin
        w_state_next  = r_state;
        w_cursor_next = r_cursor;
        w_k_next      = r_k;
        w_we          = 1'b0;
        w_waddr       = r_cursor;
        w_wdata       = BLANK;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (is_printable(in_char)) begin
                        w_we    = 1'b1;
                        w_wdata = in_char;
                        if (r_cursor == c_last_cell) begin
                            w_state_next = SCROLL;
                            w_k_next     = 5'd0;
                        end else begin
                            w_cursor_next = r_cursor + 5'd1;
                        end
                    end else if (in_char == CH_BS) begin
                        if (r_cursor != 5'd0) begin
                            w_cursor_next = r_cursor - 5'd1;
                            w_we          = 1'b1;
                            w_waddr       = r_cursor - 5'd1;
                        end
                    end else if (in_char == CH_LF) begin
                        if (r_cursor < c_row2_start) begin
                            w_cursor_next = c_row2_start;
                        end else begin
                            w_state_next = SCROLL;
                            w_k_next     = 5'd0;
                        end
                    end else if (in_char == CH_FF) begin
                        w_state_next = CLEAR;
                        w_k_next     = 5'd0;
                    end
                end
            end
            SCROLL: begin
                w_we    = 1'b1;
                w_waddr = r_k;
                w_wdata = (r_k < c_row2_start) ? r_cells[w_src_idx] : BLANK;
                if (r_k == c_last_cell) begin
                    w_state_next  = IDLE;
                    w_cursor_next = c_row2_start;
                    w_k_next      = 5'd0;
                end else begin
                    w_k_next = r_k + 5'd1;
                end
            end
            CLEAR: begin
                w_we    = 1'b1;
                w_waddr = r_k;
                if (r_k == c_last_cell) begin
                    w_state_next  = IDLE;
                    w_cursor_next = 5'd0;
                    w_k_next      = 5'd0;
                end else begin
                    w_k_next = r_k + 5'd1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Cell storage: reset blanks everything, otherwise one write per cycle
    always_ff @(posedge cclk) begin
        if (rstb) begin
            for (int i = 0; i < NCELLS; i++) begin
                r_cells[i] <= BLANK;
            end
        end else if (w_we) begin
            r_cells[w_waddr] <= w_wdata;
        end
    end

    generate
        for (genvar gi = 0; gi < NCELLS; gi++) begin : g_pack
            assign cells[8*gi +: 8] = r_cells[gi];
        end
    endgenerate

`ifdef CURSOR_BLINK_EN
    cursor_blinker #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blinker (
        .clk       (cclk),
        .rst       (rstb),
        .i_restart (w_accept),
        .i_hold    (busy),
        .o_vis     (cursor_vis)
    );
`else
    assign cursor_vis = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_text_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_text_buffer_ctrl
// Description : Self-checking bench for text_buffer_ctrl: directed scenarios
//               plus random character stream against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_text_buffer_ctrl;

    logic         cclk = 1'b0;
    logic         rstb;
    logic         in_valid;
    logic [7:0]   in_char;
    logic         in_ready;
    logic [207:0] cells;
    logic [4:0]   cursor_idx;
    logic         busy;
    logic         cursor_vis;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: plain array of 26 characters and a cursor
    byte unsigned m_cells [26];
    int           m_cur;

    always #5 cclk = ~cclk;

`ifdef CURSOR_BLINK_EN
    text_buffer_ctrl #(.BLINK_DIV(24'd4)) dut (
        .cclk(cclk), .rstb(rstb), .in_valid(in_valid), .in_char(in_char),
        .in_ready(in_ready), .cells(cells), .cursor_idx(cursor_idx),
        .busy(busy), .cursor_vis(cursor_vis)
    );
`else
    text_buffer_ctrl dut (
        .cclk(cclk), .rstb(rstb), .in_valid(in_valid), .in_char(in_char),
        .in_ready(in_ready), .cells(cells), .cursor_idx(cursor_idx),
        .busy(busy), .cursor_vis(cursor_vis)
    );
`endif

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [207:0] model_packed();
        logic [207:0] v;
        for (int i = 0; i < 26; i++) v[8*i +: 8] = m_cells[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 26; i++) m_cells[i] = 8'h20;
        m_cur = 0;
    endtask

    task automatic model_scroll();
        for (int i = 0; i < 13; i++) m_cells[i] = m_cells[i + 13];
        for (int i = 13; i < 26; i++) m_cells[i] = 8'h20;
        m_cur = 13;
    endtask

    // Applies one accepted code; returns 1 when a 26-cycle operation follows
    task automatic model_apply(input byte unsigned c, output bit long_op);
        long_op = 0;
        if (c >= 8'h20 && c <= 8'h7E) begin
            m_cells[m_cur] = c;
            if (m_cur == 25) begin model_scroll(); long_op = 1; end
            else m_cur++;
        end else if (c == 8'h08) begin
            if (m_cur > 0) begin m_cur--; m_cells[m_cur] = 8'h20; end
        end else if (c == 8'h0A) begin
            if (m_cur < 13) m_cur = 13;
            else begin model_scroll(); long_op = 1; end
        end else if (c == 8'h0C) begin
            model_reset();
            long_op = 1;
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, "_cells"}, cells, model_packed());
        chk({tag, "_cursor"}, cursor_idx, m_cur[4:0]);
    endtask

    task automatic do_reset();
        rstb = 1'b1;
        in_valid = 1'b0;
        @(posedge cclk); #1;
        model_reset();
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_vis", cursor_vis, 1'b1);
        compare_all("rst");
        rstb = 1'b0;
        #1;
        chk("rst_ready_after", in_ready, 1'b1);
    endtask

    // Presents one character, then follows any scroll/clear to completion
    // with in_valid held high so that no extra accept may slip in.
    task automatic send(input byte unsigned c, input bit full_check);
        int n;
        bit long_op;
        n = 0;
        while (!in_ready && n < 100) begin @(posedge cclk); #1; n++; end
        chk("ready_wait", in_ready, 1'b1);
        in_valid = 1'b1;
        in_char  = c;
        @(posedge cclk); #1;
        model_apply(c, long_op);
        in_char = 8'($urandom_range(32, 126));
        if (!long_op) begin
            in_valid = 1'b0;
            if (full_check) chk("busy_low", busy, 1'b0);
        end else begin
            chk("busy_rise", busy, 1'b1);
            chk("ready_drop", in_ready, 1'b0);
            n = 0;
            while (busy && n < 40) begin
                @(posedge cclk); #1;
                n++;
            end
            in_valid = 1'b0;
            chk("busy_len", n, 26);
            chk("ready_back", in_ready, 1'b1);
        end
        if (full_check || long_op) compare_all("send");
    endtask

    initial begin
        bit dummy;
        rstb = 1'b1;
        in_valid = 1'b0;
        in_char = 8'h00;
        @(posedge cclk); #1;
        do_reset();

        // "HI" back-to-back with in_valid held high
        in_valid = 1'b1;
        in_char  = 8'h48;
        chk("hi_ready0", in_ready, 1'b1);
        @(posedge cclk); #1;
        chk("hi_ready1", in_ready, 1'b1);
        in_char = 8'h49;
        @(posedge cclk); #1;
        in_valid = 1'b0;
        model_apply(8'h48, dummy);
        model_apply(8'h49, dummy);
        chk("hi_ready2", in_ready, 1'b1);
        compare_all("hi");

        // A..Z fills both rows and triggers scroll on Z
        do_reset();
        for (int i = 0; i < 26; i++) send(8'(8'h41 + i), 1'b0);
        compare_all("az");
        chk("az_c0", cells[7:0], 8'h4E);
        chk("az_c12", cells[103:96], 8'h5A);

        // Backspace down to zero and once more
        do_reset();
        send(8'h41, 1); send(8'h42, 1);
        chk("bs_c2", cursor_idx, 5'd2);
        send(8'h08, 1); chk("bs_c1", cursor_idx, 5'd1);
        send(8'h08, 1); chk("bs_c0", cursor_idx, 5'd0);
        send(8'h08, 1); chk("bs_c0b", cursor_idx, 5'd0);

        // Newline from row 1, then newline from row 2 scrolls
        do_reset();
        for (int i = 0; i < 5; i++) send(8'(8'h61 + i), 1);
        send(8'h0A, 1);
        chk("lf_cur13", cursor_idx, 5'd13);
        send(8'h51, 1);
        send(8'h0A, 1);
        chk("lf_q", cells[7:0], 8'h51);
        chk("lf_cur", cursor_idx, 5'd13);

        // Clear of a partly full buffer
        send(8'h31, 1); send(8'h32, 1);
        send(8'h0C, 1);
        chk("ff_cur", cursor_idx, 5'd0);

        // Reset on clear cycle 10 aborts immediately
        send(8'h35, 1); send(8'h36, 1);
        in_valid = 1'b1; in_char = 8'h0C;
        @(posedge cclk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge cclk); #1; end
        chk("abort_busy_pre", busy, 1'b1);
        rstb = 1'b1;
        @(posedge cclk); #1;
        model_reset();
        chk("abort_busy", busy, 1'b0);
        compare_all("abort");
        rstb = 1'b0;
        #1;
        chk("abort_ready", in_ready, 1'b1);

        // Cursor visibility
        do_reset();
`ifdef CURSOR_BLINK_EN
        for (int n = 1; n <= 16; n++) begin
            @(posedge cclk); #1;
            chk("blink_idle", cursor_vis, ((n / 4) % 2) == 0);
        end
        send(8'h41, 1);
        chk("blink_accept", cursor_vis, 1'b1);
        for (int n = 1; n <= 10; n++) begin
            @(posedge cclk); #1;
            chk("blink_restart", cursor_vis, ((n / 4) % 2) == 0);
        end
`else
        for (int n = 1; n <= 12; n++) begin
            @(posedge cclk); #1;
            chk("vis_const", cursor_vis, 1'b1);
        end
`endif

        // Random character stream against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int r;
            byte unsigned c;
            r = $urandom_range(0, 99);
            if (r < 70)      c = 8'($urandom_range(32, 126));
            else if (r < 80) c = 8'h08;
            else if (r < 88) c = 8'h0A;
            else if (r < 90) c = 8'h0C;
            else             c = 8'($urandom_range(0, 255));
            send(c, 1);
`ifndef CURSOR_BLINK_EN
            chk("rand_vis", cursor_vis, 1'b1);
`endif
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin @(posedge cclk); #1; end
            end
        end
        compare_all("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
